control_multicycle_32: RTL and testbench
========================================

# control_multicycle_32

Multi-cycle successor to the single-cycle `control_32` decoder for the 32-bit MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving datapath strobes one state at a time. It adds a memory ready/wait handshake with a parametrised timeout, a sticky trap state and a retired-instruction counter. It sits between the instruction register (`opcode`, `funct`) and the shared-memory multi-cycle datapath.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles a memory state waits for `mem_ready` before trapping; legal range 1..255.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the next FETCH completes.
- `funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completed the current read/write this cycle.
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  load PC this cycle.
- `ir_write`  out  1  load IR this cycle.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_toreg`  out  2  00 ALU, 01 MDR, 10 PC, 11 invalid.
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31, 11 invalid.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 use funct, 11 invalid.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr).
- `state`  out  4  current state code (debug).
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `retired`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.
- `err_illegal_opcode`, `err_mem_timeout`  out  1  sticky error flags.

## Operation
- Outputs are Moore, decoded from `state`, with one exception: the qualified strobes (`pc_write`, `ir_write`, `instr_done`) also depend on `mem_ready`, `zero` and `funct` as listed below. All unlisted outputs are 0. Muxes default to 00.
- FETCH (0): `mem_read`=1, `iord`=0, `alu_src_b`=01, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_source`=00, then go to DECODE.
- DECODE (1): `alu_src_b`=11, `alu_op`=00 (the branch target is precomputed into ALUOut). Dispatch on opcode:
  - lw/sw (100011/101011) -> MEMADDR
  - R-type (000000) -> EXEC
  - addi (001000) -> ADDIEX
  - beq/bne (000100/000101) -> BRANCH
  - j (000010) -> JUMP
  - jal (000011) -> JAL
  - anything else -> TRAP, and `err_illegal_opcode` is set.
- MEMADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD (3): `mem_read`=1, `iord`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB (4): `reg_write`=1, `reg_dst`=00, `mem_toreg`=01. Instruction done; go to FETCH.
- MEMWR (5): `mem_write`=1, `iord`=1. Wait for `mem_ready`; instruction done; go to FETCH.
- EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - If `funct`=001000 (jr): `pc_write`=1, `pc_source`=11, instruction done, go to FETCH.
  - Otherwise go to ALUWB.
- ALUWB (7): `reg_write`=1, `reg_dst`=01, `mem_toreg`=00. Instruction done; go to FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01.
  - `pc_write` = `zero` for beq, `~zero` for bne.
  - Instruction done; go to FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10. Instruction done; go to FETCH.
- JAL (10): `pc_write`=1, `pc_source`=10, `reg_write`=1, `reg_dst`=10, `mem_toreg`=10. The PC already holds PC+4, so that value is written to $31. Instruction done; go to FETCH.
- ADDIEX (11): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Go to ADDIWB.
- ADDIWB (12): `reg_write`=1, `reg_dst`=00, `mem_toreg`=00. Instruction done; go to FETCH.
- TRAP (15): all strobes 0, mux outputs 11. The state is held until `rst`; the error flags are sticky until `rst`.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states without `mem_ready`.
  - If it reaches `TIMEOUT` with `mem_ready` still low: go to TRAP and set `err_mem_timeout`.
  - `mem_ready` on the same cycle the count reaches `TIMEOUT` counts as success.
- "Instruction done": `instr_done`=1 for that cycle and `retired` increments on the following edge.
- Unused states 13 and 14 go to TRAP.

## Timing
- Reset: while `rst`=1 at an edge, next-state is FETCH, the wait counter is 0, `retired`=0 and both error flags are 0. In the cycle `rst` is high, all strobes are forced to 0.
- The first `mem_read` is asserted in the cycle after `rst` deasserts. Reset asserted mid-instruction abandons it with no writes.
- Latency with `mem_ready` in the first cycle of each memory state:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, bne, j, jal, jr: 3 cycles
- Each wait cycle adds 1 cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset, then R-type add with `mem_ready` tied to 1 -> states 0,1,6,7; `reg_write`=1 only in state 7; `retired` goes 0->1 after 4 cycles.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD -> total 10 cycles; `ir_write` pulses exactly once; MEMWB has `reg_dst`=00 and `mem_toreg`=01.
- beq with `zero`=1, then bne with `zero`=1 -> `pc_write`=1 in BRANCH for beq only; both instructions take 3 cycles.
- jr (opcode 0, funct 001000) -> EXEC asserts `pc_write` with `pc_source`=11, returns to FETCH with no ALUWB; jal -> `reg_dst`=10, `mem_toreg`=10.
- Opcode 111111 -> TRAP, `err_illegal_opcode`=1, state 15 held for 20 cycles; `rst` pulse -> FETCH with flags cleared.
- `TIMEOUT`=3 with `mem_ready` held low in FETCH -> TRAP after 3 cycles, `err_mem_timeout`=1; repeat with `mem_ready` arriving on the 3rd cycle -> DECODE, no error.

Source files
------------

// File: rtl/control_multicycle_32_if.sv
// Bundles the instruction-register, memory handshake and datapath strobe signals of the multi-cycle MIPS controller.
// No logic or latency of its own; purely a signal bundle.
// The controller uses the slave view; the datapath and memory side use the master view.
interface control_multicycle_32_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             zero;
  logic             pc_write;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_toreg;
  logic [1:0]       reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             err_illegal_opcode;
  logic             err_mem_timeout;

  modport master (
    output opcode, funct, mem_ready, zero,
    input  pc_write, ir_write, iord, mem_read, mem_write, mem_toreg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           instr_done, retired, err_illegal_opcode, err_mem_timeout
  );

  modport slave (
    input  opcode, funct, mem_ready, zero,
    output pc_write, ir_write, iord, mem_read, mem_write, mem_toreg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           instr_done, retired, err_illegal_opcode, err_mem_timeout
  );
endinterface

// File: rtl/control_multicycle_32.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, with memory timeout trap and retire counter.
// Per instruction (mem_ready on first try): lw 5 cycles; sw, R-type, addi 4; beq, bne, j, jal, jr 3.
// Memory states stall on mem_ready low; after TIMEOUT stalled cycles the FSM traps until rst.
module control_multicycle_32 #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  control_multicycle_32_if.slave  ctrl_if
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_JAL     = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // The wait counter holds the number of stalled cycles already spent; the
  // stall that would bring it to TIMEOUT is the one that traps.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             err_illegal_q, err_timeout_q;
  logic             set_illegal, set_timeout;
  logic             in_mem_state;

  logic pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;
  logic reg_write_raw, instr_done_raw;
  logic iord, alu_src_a;
  logic [1:0] mem_toreg, reg_dst, alu_src_b, alu_op, pc_source;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Next-state, wait counter and error-set decisions.
  always_comb begin
    state_d     = state_q;
    wait_d      = 8'd0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_FETCH:   if (ctrl_if.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl_if.opcode)
          OP_LW, OP_SW:    state_d = S_MEMADDR;
          OP_RTYPE:        state_d = S_EXEC;
          OP_ADDI:         state_d = S_ADDIEX;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default: begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (ctrl_if.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ctrl_if.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (ctrl_if.mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = (ctrl_if.funct == FN_JR) ? S_FETCH : S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_JAL:     state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
    // A stalled memory state either counts one more wait cycle or traps;
    // every other path leaves wait_d at zero, which clears it on entry.
    if (in_mem_state && !ctrl_if.mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d     = S_TRAP;
        set_timeout = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  // Moore datapath controls decoded from state, plus the qualified strobes.
  always_comb begin
    pc_write_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    iord           = 1'b0;
    alu_src_a      = 1'b0;
    mem_toreg      = 2'b00;
    reg_dst        = 2'b00;
    alu_src_b      = 2'b00;
    alu_op         = 2'b00;
    pc_source      = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = ctrl_if.mem_ready;
        pc_write_raw = ctrl_if.mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_toreg      = 2'b01;
        instr_done_raw = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw  = 1'b1;
        iord           = 1'b1;
        instr_done_raw = ctrl_if.mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        if (ctrl_if.funct == FN_JR) begin
          pc_write_raw   = 1'b1;
          pc_source      = 2'b11;
          instr_done_raw = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 2'b01;
        instr_done_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a      = 1'b1;
        alu_op         = 2'b01;
        pc_source      = 2'b01;
        // opcode[0] distinguishes bne from beq, inverting the zero test.
        pc_write_raw   = ctrl_if.zero ^ ctrl_if.opcode[0];
        instr_done_raw = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw   = 1'b1;
        pc_source      = 2'b10;
        instr_done_raw = 1'b1;
      end
      S_JAL: begin
        pc_write_raw   = 1'b1;
        pc_source      = 2'b10;
        reg_write_raw  = 1'b1;
        reg_dst        = 2'b10;
        mem_toreg      = 2'b10;
        instr_done_raw = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: begin
        // TRAP and unused codes: no strobes, every mux parked at all-ones.
        iord      = 1'b1;
        alu_src_a = 1'b1;
        mem_toreg = 2'b11;
        reg_dst   = 2'b11;
        alu_src_b = 2'b11;
        alu_op    = 2'b11;
        pc_source = 2'b11;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Retired-instruction counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q     <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (instr_done_raw) retired_q <= retired_q + CNT_W'(1);
      if (set_illegal)    err_illegal_q <= 1'b1;
      if (set_timeout)    err_timeout_q <= 1'b1;
    end
  end

  // Strobes are suppressed while rst is high so an abandoned instruction writes nothing.
  assign ctrl_if.pc_write           = pc_write_raw & ~rst;
  assign ctrl_if.ir_write           = ir_write_raw & ~rst;
  assign ctrl_if.mem_read           = mem_read_raw & ~rst;
  assign ctrl_if.mem_write          = mem_write_raw & ~rst;
  assign ctrl_if.reg_write          = reg_write_raw & ~rst;
  assign ctrl_if.instr_done         = instr_done_raw & ~rst;
  assign ctrl_if.iord               = iord;
  assign ctrl_if.alu_src_a          = alu_src_a;
  assign ctrl_if.mem_toreg          = mem_toreg;
  assign ctrl_if.reg_dst            = reg_dst;
  assign ctrl_if.alu_src_b          = alu_src_b;
  assign ctrl_if.alu_op             = alu_op;
  assign ctrl_if.pc_source          = pc_source;
  assign ctrl_if.state              = state_q;
  assign ctrl_if.retired            = retired_q;
  assign ctrl_if.err_illegal_opcode = err_illegal_q;
  assign ctrl_if.err_mem_timeout    = err_timeout_q;

endmodule

// File: tb/tb_control_multicycle_32.sv
// Bench for control_multicycle_32: directed and random instructions checked against a per-instruction cost model.
// Two instances: default TIMEOUT for function, TIMEOUT=3 for timeout boundaries.
// Memory readiness is driven by the bench, including random values where it must be ignored.
module tb_control_multicycle_32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_multicycle_32_if #(.CNT_W(32)) bus ();
  control_multicycle_32_if #(.CNT_W(32)) bus3 ();

  control_multicycle_32 #(.TIMEOUT(15), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ctrl_if(bus.slave)
  );
  control_multicycle_32 #(.TIMEOUT(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .ctrl_if(bus3.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  int unsigned exp_ret = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_strobe();
    return bus.pc_write | bus.ir_write | bus.mem_read | bus.mem_write | bus.reg_write | bus.instr_done;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;  bus.zero = 1'b1;  bus.opcode = 6'd0;  bus.funct = 6'd0;
    bus3.mem_ready = 1'b1; bus3.zero = 1'b0; bus3.opcode = 6'd0; bus3.funct = 6'd0;
    #1;
    check("rst_strobes_now", any_strobe(), 0);
    tick();
    check("rst_strobes_held", any_strobe(), 0);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_state", bus.state, 0);
    check("rst_retired", bus.retired, 0);
    check("rst_errs", {bus.err_illegal_opcode, bus.err_mem_timeout}, 0);
    check("rst_first_mem_read", bus.mem_read, 1);
    exp_ret = 0;
  endtask

  // Runs one instruction; wf/wm are stalled cycles in fetch and in the memory access.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic zf, input int wf, input int wm,
                           input bit chk_tr, input logic [63:0] exp_tr);
    bit is_lw, is_sw, is_r, is_jr, is_addi, is_beq, is_bne, is_j, is_jal, is_mem, done;
    int base, total, mstart, ncyc;
    int cnt_ir, cnt_mr, cnt_mw, cnt_rw, cnt_pw, exp_mr, exp_mw, exp_rw, exp_pw;
    logic [1:0] dst, tor, psrc, fpsrc, exp_dst, exp_tor, exp_psrc;
    logic [3:0] first_state;
    logic [63:0] tr, mask;
    bit extra_pw;
    is_lw = (op == 6'h23); is_sw = (op == 6'h2b); is_r = (op == 6'h00);
    is_jr = is_r && (fn == 6'h08); is_addi = (op == 6'h08);
    is_beq = (op == 6'h04); is_bne = (op == 6'h05); is_j = (op == 6'h02); is_jal = (op == 6'h03);
    is_mem = is_lw || is_sw;
    base = is_lw ? 5 : ((is_sw || (is_r && !is_jr) || is_addi) ? 4 : 3);
    total = base + wf + (is_mem ? wm : 0);
    mstart = wf + 3;
    exp_mr = wf + 1 + (is_lw ? wm + 1 : 0);
    exp_mw = is_sw ? wm + 1 : 0;
    exp_rw = (is_lw || (is_r && !is_jr) || is_addi || is_jal) ? 1 : 0;
    extra_pw = is_j || is_jal || is_jr || (is_beq && zf) || (is_bne && !zf);
    exp_pw = 1 + (extra_pw ? 1 : 0);
    exp_dst = is_jal ? 2'b10 : ((is_r) ? 2'b01 : 2'b00);
    exp_tor = is_jal ? 2'b10 : (is_lw ? 2'b01 : 2'b00);
    exp_psrc = is_jr ? 2'b11 : ((is_j || is_jal) ? 2'b10 : 2'b01);

    bus.opcode = op; bus.funct = fn;
    done = 0; ncyc = 0; tr = '0; first_state = 4'hx;
    cnt_ir = 0; cnt_mr = 0; cnt_mw = 0; cnt_rw = 0; cnt_pw = 0;
    dst = 2'bxx; tor = 2'bxx; psrc = 2'bxx; fpsrc = 2'bxx;
    for (int c = 0; c < 80; c++) begin
      if (c < wf) bus.mem_ready = 1'b0;
      else if (c == wf) bus.mem_ready = 1'b1;
      else if (is_mem && c >= mstart && c < mstart + wm) bus.mem_ready = 1'b0;
      else if (is_mem && c == mstart + wm) bus.mem_ready = 1'b1;
      else bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = (is_beq || is_bne) ? zf : 1'($urandom_range(0, 1));
      #1;
      if (c == 0) first_state = bus.state;
      tr = {tr[59:0], bus.state};
      cnt_ir += int'(bus.ir_write);
      cnt_mr += int'(bus.mem_read);
      cnt_mw += int'(bus.mem_write);
      cnt_rw += int'(bus.reg_write);
      cnt_pw += int'(bus.pc_write);
      if (bus.pc_write) begin
        if (c == wf) fpsrc = bus.pc_source;
        else psrc = bus.pc_source;
      end
      if (bus.reg_write) begin
        dst = bus.reg_dst;
        tor = bus.mem_toreg;
      end
      if (bus.instr_done) begin
        done = 1;
        ncyc = c + 1;
      end
      tick();
      if (done) break;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, ncyc, total);
    check({tag, "_first_state"}, first_state, 0);
    check({tag, "_ir_write"}, cnt_ir, 1);
    check({tag, "_mem_read"}, cnt_mr, exp_mr);
    check({tag, "_mem_write"}, cnt_mw, exp_mw);
    check({tag, "_reg_write"}, cnt_rw, exp_rw);
    check({tag, "_pc_write"}, cnt_pw, exp_pw);
    check({tag, "_fetch_pc_source"}, fpsrc, 2'b00);
    if (exp_rw != 0) begin
      check({tag, "_reg_dst"}, dst, exp_dst);
      check({tag, "_mem_toreg"}, tor, exp_tor);
    end
    if (extra_pw) check({tag, "_pc_source"}, psrc, exp_psrc);
    if (chk_tr) begin
      mask = (64'd1 << (4 * total)) - 64'd1;
      check({tag, "_trace"}, tr & mask, exp_tr);
    end
    check({tag, "_retired"}, bus.retired, 32'(exp_ret + 1));
    exp_ret = exp_ret + 1;
    check({tag, "_errs"}, {bus.err_illegal_opcode, bus.err_mem_timeout}, 0);
  endtask

  logic [5:0] op_tab [9] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};

  initial begin
    int bad;
    logic [5:0] fn;
    int k;

    do_reset();

    // Directed instructions with known state traces.
    run_instr("radd", 6'h00, 6'h20, 1'b0, 0, 0, 1, 64'h0167);
    run_instr("lw_wait", 6'h23, 6'h00, 1'b0, 2, 3, 1, 64'h0001233334);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 1, 64'h018);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, 1, 64'h018);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0, 1, 64'h016);
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0, 1, 64'h01A);
    run_instr("sw_wait", 6'h2b, 6'h00, 1'b0, 0, 1, 1, 64'h01255);
    run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, 1, 64'h01BC);
    run_instr("j", 6'h02, 6'h00, 1'b0, 1, 0, 1, 64'h0019);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0, 1, 64'h018);
    // Ready arrives on the last cycle before the default timeout would fire.
    run_instr("lw_edge", 6'h23, 6'h00, 1'b0, 14, 14, 0, 64'h0);

    // Random instruction mix with random stall lengths.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 8);
      fn = 6'($urandom_range(0, 63));
      if (k == 8) fn = 6'h08;
      else if (k == 2 && fn == 6'h08) fn = 6'h20;
      run_instr($sformatf("rnd%0d", i), op_tab[k], fn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4), 0, 64'h0);
    end

    // Reset in the middle of a load: abandoned with no writes, counters cleared.
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    do_reset();

    // Illegal opcode traps and holds.
    bus.opcode = 6'h3f;
    bus.mem_ready = 1'b1;
    #1;
    check("trap_fetch_state", bus.state, 0);
    tick();
    bus.mem_ready = 1'($urandom_range(0, 1));
    #1;
    check("trap_decode_state", bus.state, 1);
    check("trap_decode_flag", bus.err_illegal_opcode, 0);
    tick();
    check("trap_state", bus.state, 15);
    check("trap_illegal_flag", bus.err_illegal_opcode, 1);
    check("trap_timeout_flag", bus.err_mem_timeout, 0);
    check("trap_muxes", {bus.mem_toreg, bus.reg_dst, bus.alu_src_b, bus.alu_op, bus.pc_source}, 10'h3ff);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      if (bus.state !== 4'd15 || any_strobe() !== 1'b0) bad++;
      tick();
    end
    check("trap_hold_20", bad, 0);
    check("trap_retired", bus.retired, 0);
    check("trap_flag_sticky", bus.err_illegal_opcode, 1);
    do_reset();

    // TIMEOUT=3: fetch stalled three cycles traps.
    bad = 0;
    bus3.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus3.state !== 4'd0) bad++;
      tick();
    end
    check("to3_fetch_wait", bad, 0);
    check("to3_trap_state", bus3.state, 15);
    check("to3_timeout_flag", bus3.err_mem_timeout, 1);
    check("to3_illegal_flag", bus3.err_illegal_opcode, 0);
    do_reset();

    // TIMEOUT=3: ready on the third cycle succeeds, then a load stalls twice.
    bus3.opcode = 6'h23;
    bus3.mem_ready = 1'b0; tick(); tick();
    bus3.mem_ready = 1'b1; #1;
    check("to3_fetch_ir_write", bus3.ir_write, 1);
    tick();
    check("to3_decode_state", bus3.state, 1);
    check("to3_decode_noerr", bus3.err_mem_timeout, 0);
    tick(); tick();
    bus3.mem_ready = 1'b0; tick(); tick();
    bus3.mem_ready = 1'b1; #1;
    check("to3_memrd_state", bus3.state, 3);
    tick();
    check("to3_memwb_state", bus3.state, 4);
    check("to3_memwb_dst_toreg", {bus3.reg_dst, bus3.mem_toreg}, 4'b0001);
    tick();
    check("to3_retired", bus3.retired, 1);
    // Store stalls three cycles in MEMWR and traps.
    bus3.opcode = 6'h2b;
    bus3.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus3.mem_ready = 1'b0;
    #1;
    check("to3_memwr_state", bus3.state, 5);
    tick(); tick(); tick();
    check("to3_memwr_trap", bus3.state, 15);
    check("to3_memwr_flag", bus3.err_mem_timeout, 1);
    check("to3_memwr_retired", bus3.retired, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
